// File: rtl/pcf8574_lcd_seq.sv
// HD44780 4-bit command sequencer feeding a PCF8574 expander through an I2C byte writer.
// Runs the power-up init on its own, then splits each accepted LCD byte into four EN-toggled expander writes.
module pcf8574_lcd_seq #(
    parameter int POWERUP_CYCLES = 4000000,
    parameter int INIT_CYCLES    = 500000,
    parameter int CMD_CYCLES     = 5000,
    parameter int SLOW_CYCLES    = 200000,
    parameter int DLY_W          = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    input  logic       backlight,
    output logic [7:0] i2c_data,
    output logic       i2c_write,
    input  logic       i2c_busy,
    input  logic       i2c_error,
    output logic       init_done,
    output logic       error
);
    localparam logic [DLY_W-1:0] D_PWR  = DLY_W'(POWERUP_CYCLES);
    localparam logic [DLY_W-1:0] D_INIT = DLY_W'(INIT_CYCLES);
    localparam logic [DLY_W-1:0] D_CMD  = DLY_W'(CMD_CYCLES);
    localparam logic [DLY_W-1:0] D_SLOW = DLY_W'(SLOW_CYCLES);
    localparam logic [DLY_W-1:0] ONE    = DLY_W'(1);

    typedef enum logic [2:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_XFER, ST_DELAY} state_t;
    typedef enum logic [1:0] {XF_ISSUE, XF_START, XF_DONE} xf_t;
    typedef enum logic [1:0] {DLY_CMD, DLY_INIT, DLY_SLOW} dly_t;

    state_t           st, st_d;
    xf_t              xf, xf_d;
    dly_t             dly_sel, init_dly;
    logic [DLY_W-1:0] cnt, dly_val;
    logic [1:0]       xf_idx;
    logic [2:0]       init_step;
    logic [7:0]       byte_q, init_byte;
    logic [3:0]       nib;
    logic             rs_q, nib_only;
    logic             accept, issue, xf_fin, xf_last, dly_end, slow_cmd;

    assign in_ready = (st == ST_IDLE) && init_done;
    assign accept   = in_valid && in_ready;
    assign issue    = (st == ST_XFER) && (xf == XF_ISSUE) && !i2c_busy;
    assign xf_fin   = (st == ST_XFER) && (xf == XF_DONE) && !i2c_busy;
    assign xf_last  = nib_only ? (xf_idx == 2'd1) : (xf_idx == 2'd3);
    assign dly_end  = (cnt <= ONE);
    assign nib      = xf_idx[1] ? byte_q[3:0] : byte_q[7:4];
    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    assign slow_cmd = !in_rs && (in_data[7:2] == 6'd0) && (in_data != 8'd0);

    // Steps 0..3 are lone 0x3/0x3/0x3/0x2 nibbles (high half of byte_q), 4..7 full bytes.
    always_comb begin
        init_byte = 8'h01;
        init_dly  = DLY_SLOW;
        case (init_step)
            3'd0, 3'd1: begin init_byte = 8'h30; init_dly = DLY_INIT; end
            3'd2:       begin init_byte = 8'h30; init_dly = DLY_CMD;  end
            3'd3:       begin init_byte = 8'h20; init_dly = DLY_CMD;  end
            3'd4:       begin init_byte = 8'h28; init_dly = DLY_CMD;  end
            3'd5:       begin init_byte = 8'h0C; init_dly = DLY_CMD;  end
            3'd6:       begin init_byte = 8'h06; init_dly = DLY_CMD;  end
            default:    begin init_byte = 8'h01; init_dly = DLY_SLOW; end
        endcase
    end

    always_comb begin
        dly_val = D_CMD;
        case (dly_sel)
            DLY_INIT: dly_val = D_INIT;
            DLY_SLOW: dly_val = D_SLOW;
            default:  dly_val = D_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st <= ST_POWERUP;
            xf <= XF_ISSUE;
        end else begin
            st <= st_d;
            xf <= xf_d;
        end
    end

    always_comb begin
        st_d = st;
        xf_d = xf;
        case (st)
            ST_POWERUP: if (dly_end) st_d = ST_INIT;
            ST_INIT: begin
                st_d = ST_XFER;
                xf_d = XF_ISSUE;
            end
            ST_IDLE: if (accept) begin
                st_d = ST_XFER;
                xf_d = XF_ISSUE;
            end
            ST_XFER: begin
                case (xf)
                    XF_ISSUE: if (!i2c_busy) xf_d = XF_START;
                    XF_START: if (i2c_busy) xf_d = XF_DONE;
                    XF_DONE: if (!i2c_busy) begin
                        xf_d = XF_ISSUE;
                        if (xf_last) st_d = ST_DELAY;
                    end
                    default: xf_d = XF_ISSUE;
                endcase
            end
            ST_DELAY: if (dly_end) st_d = (init_done || init_step == 3'd7) ? ST_IDLE : ST_INIT;
            default: st_d = ST_POWERUP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= D_PWR;
            i2c_data  <= 8'h00;
            i2c_write <= 1'b0;
            init_done <= 1'b0;
            error     <= 1'b0;
            xf_idx    <= 2'd0;
            init_step <= 3'd0;
            byte_q    <= 8'h00;
            rs_q      <= 1'b0;
            nib_only  <= 1'b0;
            dly_sel   <= DLY_CMD;
        end else begin
            i2c_write <= 1'b0;
            if ((st == ST_POWERUP || st == ST_DELAY) && !dly_end)
                cnt <= cnt - ONE;
            if (st == ST_DELAY && dly_end && !init_done) begin
                if (init_step == 3'd7) init_done <= 1'b1;
                else                   init_step <= init_step + 3'd1;
            end
            if (st == ST_INIT) begin
                byte_q   <= init_byte;
                rs_q     <= 1'b0;
                nib_only <= !init_step[2];
                dly_sel  <= init_dly;
                xf_idx   <= 2'd0;
            end
            if (accept) begin
                byte_q   <= in_data;
                rs_q     <= in_rs;
                nib_only <= 1'b0;
                dly_sel  <= slow_cmd ? DLY_SLOW : DLY_CMD;
                xf_idx   <= 2'd0;
            end
            // Even transfer index carries EN=1, the following odd one drops EN to latch.
            if (issue) begin
                i2c_data  <= {nib, backlight, ~xf_idx[0], 1'b0, rs_q};
                i2c_write <= 1'b1;
            end
            if (xf_fin) begin
                if (i2c_error) error <= 1'b1;
                if (xf_last) cnt    <= dly_val;
                else         xf_idx <= xf_idx + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_pcf8574_lcd_seq.sv
// Directed bench for pcf8574_lcd_seq with a behavioural I2C stage (busy 2 cycles after strobe, held 5).
module tb_pcf8574_lcd_seq;
    localparam int PWR  = 10;
    localparam int INI  = 30;
    localparam int CMD  = 20;
    localparam int SLOW = 60;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_rs = 1'b0, backlight = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       i2c_error = 1'b0, m_busy = 1'b0, hold_busy = 1'b0;
    logic       in_ready, i2c_write, init_done, error, i2c_busy;
    logic [7:0] i2c_data;

    int n_chk = 0, n_err = 0, cyc = 0, last_fall = 0, m_cnt = 0, viol = 0, err_at = -1;
    logic       err_pend = 1'b0;
    logic [7:0] wr_q [$];
    int         wr_cyc [$];

    logic [7:0] init_exp [24] = '{8'h3C, 8'h38, 8'h3C, 8'h38, 8'h3C, 8'h38, 8'h2C, 8'h28,
                                  8'h2C, 8'h28, 8'h8C, 8'h88, 8'h0C, 8'h08, 8'hCC, 8'hC8,
                                  8'h0C, 8'h08, 8'h6C, 8'h68, 8'h0C, 8'h08, 8'h1C, 8'h18};
    logic [7:0] b2b_exp [12] = '{8'h4D, 8'h49, 8'h1D, 8'h19, 8'h4D, 8'h49, 8'h2D, 8'h29,
                                 8'h4D, 8'h49, 8'h3D, 8'h39};

    assign i2c_busy = m_busy | hold_busy;

    pcf8574_lcd_seq #(
        .POWERUP_CYCLES(PWR), .INIT_CYCLES(INI), .CMD_CYCLES(CMD),
        .SLOW_CYCLES(SLOW), .DLY_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_data(in_data), .backlight(backlight),
        .i2c_data(i2c_data), .i2c_write(i2c_write), .i2c_busy(i2c_busy),
        .i2c_error(i2c_error), .init_done(init_done), .error(error)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // I2C stage model, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            i2c_error = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 5) m_busy = 1'b1;
                if (m_cnt == 0) begin
                    m_busy    = 1'b0;
                    last_fall = cyc;
                    if (err_pend) begin
                        i2c_error = 1'b1;
                        err_pend  = 1'b0;
                    end
                end
            end
            if (i2c_write) begin
                if (m_cnt > 0 || i2c_busy) viol++;
                wr_q.push_back(i2c_data);
                wr_cyc.push_back(cyc);
                if (wr_q.size() == err_at) err_pend = 1'b1;
                m_cnt = 7;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (in_ready !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_init(input int base, input int rel);
        int t = 0;
        while (init_done !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("init_done", init_done, 1);
        chk("init_rdy", in_ready, 1);
        chk("init_nwr", wr_q.size() - base, 24);
        chk("pwr_wait", (wr_cyc.size() > base) ? ((wr_cyc[base] - rel) >= PWR) : 1'b0, 1);
        for (int i = 0; i < 24; i++)
            chk($sformatf("init_b%0d", i),
                (wr_q.size() > base + i) ? 32'(wr_q[base + i]) : 32'hFFFF, 32'(init_exp[i]));
    endtask

    task automatic send_byte(input string tag, input logic rs, input logic [7:0] d,
                             input logic [31:0] exp_b, input int exp_gap);
        int n0;
        wait_ready(tag);
        n0 = wr_q.size();
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_rdy0"}, in_ready, 0);
        wait_ready(tag);
        chk({tag, "_nwr"}, wr_q.size() - n0, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_b%0d", tag, i),
                (wr_q.size() > n0 + i) ? 32'(wr_q[n0 + i]) : 32'hFFFF, 32'(exp_b[31 - 8*i -: 8]));
        chk({tag, "_gap"}, cyc - last_fall, exp_gap);
    endtask

    initial begin
        int base, rel, n0, t;
        repeat (3) @(negedge clk);
        chk("rst_rdy", in_ready, 0);
        chk("rst_wr", i2c_write, 0);
        chk("rst_data", i2c_data, 8'h00);
        chk("rst_init", init_done, 0);
        chk("rst_err", error, 0);

        base  = wr_q.size();
        rst_n = 1'b1;
        rel   = cyc;
        check_init(base, rel);

        backlight = 1'b0;
        send_byte("chr41", 1'b1, 8'h41, 32'h45411511, CMD + 1);
        backlight = 1'b1;
        send_byte("clr01", 1'b0, 8'h01, 32'h0C081C18, SLOW + 1);
        send_byte("cmd80", 1'b0, 8'h80, 32'h8C880C08, CMD + 1);
        send_byte("home02", 1'b0, 8'h02, 32'h0C082C28, SLOW + 1);
        send_byte("cmd03", 1'b0, 8'h03, 32'h0C083C38, SLOW + 1);
        send_byte("cmd04", 1'b0, 8'h04, 32'h0C084C48, CMD + 1);
        send_byte("cmd00", 1'b0, 8'h00, 32'h0C080C08, CMD + 1);
        send_byte("chr01", 1'b1, 8'h01, 32'h0D091D19, CMD + 1);

        chk("err_pre", error, 0);
        err_at = wr_q.size() + 2;
        send_byte("err1", 1'b1, 8'h5A, 32'h5D59ADA9, CMD + 1);
        chk("err_set", error, 1);
        send_byte("err2", 1'b1, 8'hA5, 32'hADA95D59, CMD + 1);
        chk("err_sticky", error, 1);

        // Busy held on entry, then three bytes with in_valid never dropped.
        hold_busy = 1'b1;
        n0 = wr_q.size();
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h41;
        @(negedge clk);
        chk("hold_acc", in_ready, 0);
        in_data = 8'h42;
        repeat (15) @(negedge clk);
        chk("hold_nwr", wr_q.size() - n0, 0);
        hold_busy = 1'b0;
        wait_ready("b2b1");
        @(negedge clk);
        chk("b2b_rdy1", in_ready, 0);
        in_data = 8'h43;
        wait_ready("b2b2");
        @(negedge clk);
        chk("b2b_rdy2", in_ready, 0);
        in_valid = 1'b0;
        wait_ready("b2b3");
        chk("b2b_nwr", wr_q.size() - n0, 12);
        for (int i = 0; i < 12; i++)
            chk($sformatf("b2b_b%0d", i),
                (wr_q.size() > n0 + i) ? 32'(wr_q[n0 + i]) : 32'hFFFF, 32'(b2b_exp[i]));

        // Reset in the middle of a byte.
        n0 = wr_q.size();
        in_valid = 1'b1;
        in_rs    = 1'b0;
        in_data  = 8'h28;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (wr_q.size() < n0 + 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("mid_nwr", wr_q.size() - n0, 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr", i2c_write, 0);
        chk("mid_rst_init", init_done, 0);
        chk("mid_rst_rdy", in_ready, 0);
        chk("mid_rst_err", error, 0);
        base  = wr_q.size();
        rst_n = 1'b1;
        rel   = cyc;
        check_init(base, rel);

        chk("strobe_overlap", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pcf8574_lcd_seq.md
Name: pcf8574_lcd_seq

Overview:
- Command sequencer that sits directly upstream of the I2C byte-writer stage.
- Drives an HD44780 LCD in 4-bit mode through a PCF8574 I/O expander.
- Accepts LCD bytes (command or character) on a valid/ready handshake and breaks each into four expander bytes, toggling EN around each nibble.
- Paces each byte through the I2C stage's write/busy handshake and enforces LCD execution delays.
- Performs the power-up init sequence autonomously after reset.

Parameters:
- POWERUP_CYCLES, 4000000: wait after reset before the first transfer (40 ms @100 MHz).
- INIT_CYCLES, 500000: wait after each of the first two init nibbles 0x3 (5 ms).
- CMD_CYCLES, 5000: wait after every normal LCD byte and after the third/fourth init nibbles (50 us).
- SLOW_CYCLES, 200000: wait after commands 0x01 and 0x02/0x03 (2 ms).
- DLY_W, 32: width of the delay counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream byte available
- in_ready  out  1  sequencer can accept a byte
- in_rs  in  1  0 = command, 1 = character data
- in_data  in  8  LCD byte
- backlight  in  1  expander P3; sampled into every expander byte
- i2c_data  out  8  byte presented to the I2C stage
- i2c_write  out  1  one-cycle write strobe to the I2C stage
- i2c_busy  in  1  I2C stage busy
- i2c_error  in  1  I2C stage error flag
- init_done  out  1  init sequence complete
- error  out  1  sticky; set if i2c_error is high when a transfer completes

Behaviour:
- Clock and reset: reset is rst_n, synchronous, active-low; clock is clk.
- Reset values: in_ready=0, i2c_write=0, i2c_data=0x00, init_done=0, error=0, state=POWERUP, delay counter loaded with POWERUP_CYCLES.
- Reset asserted mid-operation aborts the current transfer immediately. No further i2c_write is issued until the power-up wait has elapsed again.
- Expander byte format: {nib[3:0], backlight, EN, RW=0, RS}.
- Nibble emit: two transfers.
  - First transfer has EN=1.
  - Second transfer has EN=0, same nib and RS.
  - The EN=1→0 edge latches the nibble in the LCD.
- Byte emit: high nibble first, then low nibble, giving 4 transfers in total.
- Transfer sub-FSM:
  - XF_ISSUE: wait for i2c_busy=0. Drive i2c_data, pulse i2c_write for exactly 1 cycle.
  - XF_START: wait for i2c_busy=1 (the I2C stage raises busy 1–2 cycles after the strobe).
  - XF_DONE: wait for i2c_busy=0. If i2c_error=1 in that cycle, set error. Then return to the caller.
  - i2c_data is held stable from XF_ISSUE until XF_DONE exits.
- Delay: after the last transfer of a nibble/byte, load the counter and count down to 0. A delay value of 0 or 1 costs exactly 1 cycle.
- Main FSM:
  - POWERUP: count POWERUP_CYCLES, then go to INIT_NIB.
  - INIT_NIB, index 0..3: send nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. Delays after each are INIT, INIT, CMD, CMD.
  - INIT_CMD, index 0..3: send bytes 0x28, 0x0C, 0x06, 0x01 with RS=0. Delays after each are CMD, CMD, CMD, SLOW.
  - Then set init_done=1 (it stays 1 until reset) and go to IDLE.
  - IDLE: in_ready=1. When in_valid && in_ready, capture in_data/in_rs, drop in_ready the next cycle, and go to SEND.
  - SEND: byte emit, then DELAY, then IDLE.
  - The delay after a byte is SLOW if in_rs=0 and in_data[7:2]==0 with in_data!=0 (i.e. 0x01–0x03). Otherwise it is CMD.
- in_ready is 1 only in IDLE with init_done=1. At most one byte is accepted per IDLE visit. Throughput is 1 byte per (4 transfers + delay).
- backlight is sampled at each XF_ISSUE, so a change takes effect on the next expander byte.
- error never blocks sequencing. The FSM continues after an error.

Test Plan:
- Reset, POWERUP_CYCLES=10, small delays, I2C model raises busy 2 cycles after the strobe and holds it 5 cycles -> no strobe before 10 cycles. Init expander bytes are 0x3C,0x38 ×3, then 0x2C,0x28, then byte 0x28 as 0x2C,0x28,0x8C,0x88, …, ending with 0x01. Then init_done=1 and in_ready=1 (backlight=1).
- After init, in_rs=1, in_data=0x41, backlight=0 -> i2c_data sequence 0x45,0x41,0x15,0x11 with one-cycle i2c_write strobes. in_ready=0 throughout and returns to 1 after CMD_CYCLES.
- Command 0x01 (clear) -> SLOW_CYCLES delay. Command 0x80 -> CMD_CYCLES delay. Measure the gap from the last busy fall to in_ready.
- I2C model asserts i2c_error on the 2nd transfer -> error=1 stays sticky. All 4 transfers still issue and the next byte is accepted.
- in_valid held high with back-to-back bytes -> exactly one accept per IDLE visit, no byte dropped or duplicated. Model holds busy=1 on entry -> strobe waits until busy=0.
- rst_n asserted mid-SEND -> i2c_write=0, init_done=0, in_ready=0, error=0 next cycle. Full init repeats.
